// File: rtl/pdl_race_sampler.sv
// rtl/pdl_race_sampler.sv - PDL race launch/capture with TRIALS-way majority vote.
// Optional PDL_STABILITY_EN adds resp_stable (all trials agreed).
module pdl_race_sampler #(
  parameter int CTRL_W     = 125,
  parameter int SETTLE_CYC = 16,
  parameter int RELAX_CYC  = 16,
  parameter int TRIALS     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CTRL_W-1:0] challenge,
  output logic              busy,
  output logic [CTRL_W-1:0] ctrl,
  output logic              launch,
  output logic              arb_clr,
  input  logic              arb_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
`ifdef PDL_STABILITY_EN
  output logic              resp_stable,
`endif
  output logic [7:0]        ones_count
);

  localparam int MAX_CYC = (SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, SAMPLE, RELAX, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       ones;
  logic [7:0]       trial;
  logic             arb_s1, arb_s2;

  // arb_in is the arbiter latch output and is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_s1 <= 1'b0;
      arb_s2 <= 1'b0;
    end else begin
      arb_s1 <= arb_in;
      arb_s2 <= arb_s1;
    end
  end

  // Outputs are set on the edge entering each state so launch/arb_clr are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ones       <= '0;
      trial      <= '0;
      busy       <= 1'b0;
      ctrl       <= '0;
      launch     <= 1'b0;
      arb_clr    <= 1'b0;
      resp_valid <= 1'b0;
      resp_bit   <= 1'b0;
      ones_count <= '0;
`ifdef PDL_STABILITY_EN
      resp_stable <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ctrl    <= challenge;
            busy    <= 1'b1;
            ones    <= '0;
            trial   <= '0;
            arb_clr <= 1'b1;
            launch  <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          arb_clr <= 1'b0;
          launch  <= 1'b1;
          cnt     <= '0;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          ones    <= ones + {7'd0, arb_s2};
          trial   <= trial + 8'd1;
          launch  <= 1'b0;
          arb_clr <= 1'b1;
          cnt     <= '0;
          state   <= RELAX;
        end
        RELAX: begin
          if (cnt == CNT_W'(RELAX_CYC - 1)) begin
            arb_clr <= 1'b0;
            cnt     <= '0;
            if (trial == 8'(TRIALS)) begin
              resp_valid <= 1'b1;
              resp_bit   <= (ones > 8'(TRIALS / 2));
              ones_count <= ones;
`ifdef PDL_STABILITY_EN
              resp_stable <= (ones == 8'd0) || (ones == 8'(TRIALS));
`endif
              state      <= DONE;
            end else begin
              launch <= 1'b1;
              state  <= SETTLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef PDL_STABILITY_EN
            resp_stable <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdl_race_sampler.sv
// tb/tb_pdl_race_sampler.sv - scoreboard bench for pdl_race_sampler (TRIALS=5, SETTLE=RELAX=4).
module tb_pdl_race_sampler;
  localparam int CW  = 125;
  localparam int T   = 5;
  localparam int S   = 4;
  localparam int R   = 4;
  localparam int LAT = 1 + T * (S + 1 + R);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] challenge = '0;
  logic          arb_in = 1'b0;
  logic          resp_ready = 1'b0;
  logic          busy, launch, arb_clr, resp_valid, resp_bit;
  logic [CW-1:0] ctrl;
  logic [7:0]    ones_count;
`ifdef PDL_STABILITY_EN
  logic          resp_stable;
`endif

  pdl_race_sampler #(.CTRL_W(CW), .SETTLE_CYC(S), .RELAX_CYC(R), .TRIALS(T)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .busy(busy),
    .ctrl(ctrl), .launch(launch), .arb_clr(arb_clr), .arb_in(arb_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
`ifdef PDL_STABILITY_EN
    .resp_stable(resp_stable),
`endif
    .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rbit;
    logic [7:0]    ones;
    logic [CW-1:0] ch;
    logic          stable;
    int            acc;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [T-1:0] pat = '0;
  int           tidx = 0;
  int           lc = 0;
  int           both = 0;
  int           nresp = 0;
  logic         launch_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rand_ch();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[CW-1:0];
  endfunction

  // Present the next trial's arbiter value on each launch rising edge.
  always @(negedge clk) begin
    if (launch && !launch_q && tidx < T) begin
      arb_in = pat[tidx];
      tidx++;
    end
    launch_q = launch;
    if (launch && arb_clr) both++;
    if (launch) lc++;
  end

  // Monitor: pops and compares on each response, then performs the handshake.
  initial begin
    exp_t e;
    int d;
    logic b0, s0;
    logic [7:0] o0;
    forever begin
      @(negedge clk);
      if (resp_valid && !rst) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 128'(resp_valid), 128'd0);
        end else begin
          e = sbq.pop_front();
          chk("resp_bit", 128'(resp_bit), 128'(e.rbit));
          chk("ones_count", 128'(ones_count), 128'(e.ones));
          chk("ctrl", 128'(ctrl), 128'(e.ch));
          chk("latency", 128'(cyc - e.acc), 128'(LAT));
          chk("launch_cycles", 128'(lc), 128'(T * (S + 1)));
`ifdef PDL_STABILITY_EN
          chk("resp_stable", 128'(resp_stable), 128'(e.stable));
`endif
        end
        d = (nresp == 0) ? 10 : int'($urandom_range(0, 10));
        nresp++;
        b0 = resp_bit;
        o0 = ones_count;
        s0 = 1'b1;
        repeat (d) begin
          @(negedge clk);
          if (resp_valid !== 1'b1 || resp_bit !== b0 || ones_count !== o0 || busy !== 1'b1) s0 = 1'b0;
        end
        chk("hold_in_done", 128'(s0), 128'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("handshake_idle", 128'({resp_valid, busy}), 128'd0);
      end
    end
  end

  task automatic run(input logic [CW-1:0] ch, input logic [T-1:0] p,
                     input bit push, input bit midstart, input bit abort);
    int n;
    int ones;
    exp_t e;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("idle_wait_timeout", 128'(busy), 128'd0);
      return;
    end
    @(negedge clk);
    pat = p;
    tidx = 0;
    lc = 0;
    challenge = ch;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    challenge = rand_ch();
    if (push) begin
      ones = $countones(p);
      e.rbit = (ones > T / 2);
      e.ones = 8'(ones);
      e.ch = ch;
      e.stable = (ones == 0) || (ones == T);
      e.acc = cyc;
      sbq.push_back(e);
    end
    if (midstart) begin
      repeat (20) @(negedge clk);
      challenge = rand_ch();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ctrl_mid_run", 128'(ctrl), 128'(ch));
    end
    if (abort) begin
      n = 0;
      while (tidx < 3 && n < 400) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_outputs", 128'({launch, arb_clr, busy, resp_valid, ctrl}), 128'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("abort_no_resp", 128'({busy, resp_valid}), 128'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({busy, launch, arb_clr, resp_valid, resp_bit, ones_count}), 128'd0);
    chk("reset_ctrl", 128'(ctrl), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    run(CW'(128'hAAAAAAAA), 5'b11111, 1, 0, 0);
    run(rand_ch(), 5'b00101, 1, 0, 0);
    run(rand_ch(), T'($urandom), 1, 1, 0);
    run(rand_ch(), T'($urandom), 0, 0, 1);
    run(rand_ch(), 5'b00000, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run(rand_ch(), T'($urandom), 1, bit'($urandom_range(0, 1)), 0);
    end

    n = 0;
    while ((sbq.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
    repeat (5) @(negedge clk);
    chk("launch_arb_clr_exclusive", 128'(both), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
